mem_port_arbiter: RTL and testbench

Shares one single-port, variable-latency memory between the instruction-fetch requester and the load/store requester of the CPU core. Two-requester round-robin arbitration, per-transaction capture of address/data/size, a bounded-wait timeout that returns an error instead of hanging the core, and a registered response routed back to the winner. Sits between `cpu_top`'s fetch/data interfaces and the unified memory model.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/arb_rr2.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the fetch/data memory port arbiter.
//   - arb_state_e : arbiter FSM states
//   - owner_e     : which requester owns the in-flight transaction
//   - FUNCT3_WORD : access size used for instruction fetches (32-bit word)
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    localparam logic [2:0] FUNCT3_WORD = 3'b010;

endpackage

// File: rtl/arb_rr2.sv
// arb_rr2: two-input round-robin pick.
//   en         in   arbitration allowed this cycle
//   req_fetch  in   fetch requester wants the port
//   req_data   in   data requester wants the port
//   last_d     in   1 = data requester was served last
//   sel_fetch  out  fetch wins this cycle
//   sel_data   out  data wins this cycle
//   last_d_nxt out  updated last-served flag (unchanged when nothing picked)
module arb_rr2 (
    input  logic en,
    input  logic req_fetch,
    input  logic req_data,
    input  logic last_d,
    output logic sel_fetch,
    output logic sel_data,
    output logic last_d_nxt
);

    always_comb begin
        sel_fetch  = 1'b0;
        sel_data   = 1'b0;
        last_d_nxt = last_d;
        if (en) begin
            if (req_fetch && req_data) begin
                // Tie: whoever was not served last goes now.
                sel_data  = ~last_d;
                sel_fetch = last_d;
            end else begin
                sel_fetch = req_fetch;
                sel_data  = req_data;
            end
        end
        if (sel_fetch) begin
            last_d_nxt = 1'b0;
        end else if (sel_data) begin
            last_d_nxt = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port, variable-latency memory between
// the instruction-fetch and load/store requesters of the core.
//   clk, rst                    clock, synchronous active-high reset
//   if_req/if_addr              fetch request (read-only)
//   if_gnt                      fetch accepted this cycle (combinational)
//   if_rvalid/if_rdata/if_err   fetch completion pulse, data, timeout error
//   d_req/d_we/d_addr/d_wdata/d_funct3  load/store request
//   d_gnt/d_rvalid/d_rdata/d_err        as fetch equivalents
//   m_req/m_we/m_addr/m_wdata/m_funct3  memory request, held until ack/timeout
//   m_ack/m_rdata               memory completion and read data
//   busy                        a transaction is in flight (not IDLE)
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [2:0]        d_funct3,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [2:0]        m_funct3,
    input  logic              m_ack,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              last_d_q, last_d_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic sel_fetch, sel_data, last_d_nxt;
    logic timeout_hit;
    logic resp_fetch, resp_data;

    // Arbitration only happens in IDLE; reset masks grants so a requester
    // never sees a handshake that the state register then throws away.
    arb_rr2 u_arb (
        .en         (state_q == ST_IDLE && !rst),
        .req_fetch  (if_req),
        .req_data   (d_req),
        .last_d     (last_d_q),
        .sel_fetch  (sel_fetch),
        .sel_data   (sel_data),
        .last_d_nxt (last_d_nxt)
    );

    // cnt_q counts completed ACCESS cycles; on the TIMEOUT-th cycle it holds
    // TIMEOUT-1, so m_req is high for exactly TIMEOUT cycles.
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d_d = last_d_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        funct3_d = funct3_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_fetch || sel_data) begin
                    owner_d  = sel_data ? OWN_DATA : OWN_FETCH;
                    last_d_d = last_d_nxt;
                    cnt_d    = '0;
                    if (sel_data) begin
                        we_d     = d_we;
                        addr_d   = d_addr;
                        wdata_d  = d_wdata;
                        funct3_d = d_funct3;
                    end else begin
                        we_d     = 1'b0;
                        addr_d   = if_addr;
                        wdata_d  = '0;
                        funct3_d = FUNCT3_WORD;
                    end
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                cnt_d = cnt_q + CNT_W'(1);
                // An ack on the timeout cycle still counts as a normal completion.
                if (m_ack) begin
                    rdata_d = we_q ? '0 : m_rdata;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (timeout_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWN_FETCH;
            last_d_q <= 1'b1;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= FUNCT3_WORD;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_d_q <= last_d_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            funct3_q <= funct3_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign if_gnt = sel_fetch;
    assign d_gnt  = sel_data;

    assign m_req    = (state_q == ST_ACCESS);
    assign m_we     = we_q;
    assign m_addr   = addr_q;
    assign m_wdata  = wdata_q;
    assign m_funct3 = funct3_q;
    assign busy     = (state_q != ST_IDLE);

    // Response fields are zero except on the owner's single RESP cycle.
    assign resp_fetch = (state_q == ST_RESP) && (owner_q == OWN_FETCH);
    assign resp_data  = (state_q == ST_RESP) && (owner_q == OWN_DATA);

    assign if_rvalid = resp_fetch;
    assign if_rdata  = resp_fetch ? rdata_q : '0;
    assign if_err    = resp_fetch & err_q;
    assign d_rvalid  = resp_data;
    assign d_rdata   = resp_data ? rdata_q : '0;
    assign d_err     = resp_data & err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic [2:0]  d_funct3 = 3'b010;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic        m_req, m_we, busy;
    logic [31:0] m_addr, m_wdata;
    logic [2:0]  m_funct3;
    logic        m_ack = 1'b0;
    logic [31:0] m_rdata = '0;

    int n_checks = 0;
    int n_pass   = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_funct3(d_funct3), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .d_err(d_err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_funct3(m_funct3), .m_ack(m_ack), .m_rdata(m_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Inputs are driven 1 ns after the rising edge, outputs sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_req = 1'b1; d_req = 1'b1;
        step(); step();
        #1;
        n_checks++;
        if ({if_gnt, d_gnt, m_req, busy, if_rvalid, d_rvalid, if_err, d_err} !== 8'b0)
            $display("FAIL reset_ctrl got %b want 00000000",
                     {if_gnt, d_gnt, m_req, busy, if_rvalid, d_rvalid, if_err, d_err});
        else n_pass++;
        n_checks++;
        if ({m_we, m_addr, m_wdata, m_funct3, if_rdata, d_rdata} !== {1'b0, 96'h0, 3'b010, 64'h0})
            $display("FAIL reset_data m_we=%b m_addr=%h m_wdata=%h m_funct3=%b want 0/0/0/010",
                     m_we, m_addr, m_wdata, m_funct3);
        else n_pass++;
        if_req = 1'b0; d_req = 1'b0;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_fetch_basic();
        if_req = 1'b1; if_addr = 32'h40;
        #1;
        n_checks++;
        if ({if_gnt, d_gnt} !== 2'b10) $display("FAIL fetch_gnt got %b want 10", {if_gnt, d_gnt});
        else n_pass++;
        step(); if_req = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            n_checks++;
            if ({m_req, m_we, m_addr, m_funct3, if_gnt} !== {1'b1, 1'b0, 32'h40, 3'b010, 1'b0})
                $display("FAIL fetch_mreq_c%0d m_req=%b m_we=%b m_addr=%h f3=%b want 1/0/40/010",
                         c, m_req, m_we, m_addr, m_funct3);
            else n_pass++;
            if (c == 3) begin m_ack = 1'b1; m_rdata = 32'h00500093; end
            step();
        end
        m_ack = 1'b0;
        #1;
        n_checks++;
        if ({if_rvalid, if_err, if_rdata, d_rvalid, d_err, d_rdata, m_req} !==
            {1'b1, 1'b0, 32'h00500093, 1'b0, 1'b0, 32'h0, 1'b0})
            $display("FAIL fetch_resp if_rvalid=%b if_err=%b if_rdata=%h d_rvalid=%b want 1/0/00500093/0",
                     if_rvalid, if_err, if_rdata, d_rvalid);
        else n_pass++;
        step();
        n_checks++;
        if ({busy, if_rvalid} !== 2'b00) $display("FAIL fetch_idle busy/rvalid got %b want 00", {busy, if_rvalid});
        else n_pass++;
    endtask

    task automatic test_alternation();
        rst = 1'b1; step(); rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; d_funct3 = 3'b010;
        for (int r = 0; r < 3; r++) begin
            #1;
            n_checks++;
            if ({if_gnt, d_gnt} !== ((r % 2 == 1) ? 2'b01 : 2'b10))
                $display("FAIL alt_round%0d gnt got %b want %b", r, {if_gnt, d_gnt},
                         (r % 2 == 1) ? 2'b01 : 2'b10);
            else n_pass++;
            step();
            n_checks++;
            if (m_addr !== ((r % 2 == 1) ? 32'h20 : 32'h10))
                $display("FAIL alt_addr%0d got %h want %h", r, m_addr, (r % 2 == 1) ? 32'h20 : 32'h10);
            else n_pass++;
            m_ack = 1'b1; m_rdata = 32'(r);
            step(); m_ack = 1'b0;
            step();
        end
        if_req = 1'b0; d_req = 1'b0;
        step(); step();
    endtask

    task automatic test_store();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_funct3 = 3'b000;
        #1;
        n_checks++;
        if ({if_gnt, d_gnt} !== 2'b01) $display("FAIL store_gnt got %b want 01", {if_gnt, d_gnt});
        else n_pass++;
        step(); d_req = 1'b0; d_wdata = 32'h0; d_addr = 32'h0;
        for (int c = 1; c <= 2; c++) begin
            n_checks++;
            if ({m_req, m_we, m_addr, m_wdata, m_funct3} !== {1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 3'b000})
                $display("FAIL store_fields_c%0d m_we=%b m_addr=%h m_wdata=%h f3=%b want 1/100/deadbeef/000",
                         c, m_we, m_addr, m_wdata, m_funct3);
            else n_pass++;
            if (c == 2) begin m_ack = 1'b1; m_rdata = 32'h12345678; end
            step();
        end
        m_ack = 1'b0;
        #1;
        n_checks++;
        if ({d_rvalid, d_err, d_rdata, if_rvalid} !== {1'b1, 1'b0, 32'h0, 1'b0})
            $display("FAIL store_resp d_rvalid=%b d_err=%b d_rdata=%h if_rvalid=%b want 1/0/0/0",
                     d_rvalid, d_err, d_rdata, if_rvalid);
        else n_pass++;
        d_we = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_funct3 = 3'b010;
        #1;
        step(); d_req = 1'b0;
        for (int c = 1; c <= TO; c++) begin
            n_checks++;
            if (m_req !== 1'b1) $display("FAIL timeout_mreq_c%0d got %b want 1", c, m_req);
            else n_pass++;
            step();
        end
        #1;
        n_checks++;
        if ({m_req, d_rvalid, d_err, d_rdata, if_rvalid} !== {1'b0, 1'b1, 1'b1, 32'h0, 1'b0})
            $display("FAIL timeout_resp m_req=%b d_rvalid=%b d_err=%b d_rdata=%h want 0/1/1/0",
                     m_req, d_rvalid, d_err, d_rdata);
        else n_pass++;
        step();
        m_ack = 1'b1; m_rdata = 32'hFFFF;
        step(); m_ack = 1'b0;
        #1;
        n_checks++;
        if ({busy, m_req, d_rvalid, if_rvalid} !== 4'b0)
            $display("FAIL late_ack busy=%b m_req=%b d_rvalid=%b if_rvalid=%b want 0000",
                     busy, m_req, d_rvalid, if_rvalid);
        else n_pass++;
    endtask

    task automatic test_ack_on_timeout();
        step();
        if_req = 1'b1; if_addr = 32'h80;
        step(); if_req = 1'b0;
        for (int c = 1; c <= TO; c++) begin
            if (c == TO) begin m_ack = 1'b1; m_rdata = 32'hCAFEF00D; end
            step();
        end
        m_ack = 1'b0;
        #1;
        n_checks++;
        if ({if_rvalid, if_err, if_rdata} !== {1'b1, 1'b0, 32'hCAFEF00D})
            $display("FAIL ack_on_timeout if_rvalid=%b if_err=%b if_rdata=%h want 1/0/cafef00d",
                     if_rvalid, if_err, if_rdata);
        else n_pass++;
        step();
    endtask

    task automatic test_rst_mid();
        if_req = 1'b1; if_addr = 32'h300;
        #1;
        n_checks++;
        if (if_gnt !== 1'b1) $display("FAIL rstmid_gnt got %b want 1", if_gnt);
        else n_pass++;
        step(); if_req = 1'b0;
        step(); rst = 1'b1;
        step();
        n_checks++;
        if ({m_req, busy, if_rvalid, d_rvalid} !== 4'b0)
            $display("FAIL rstmid_drop m_req=%b busy=%b if_rvalid=%b d_rvalid=%b want 0000",
                     m_req, busy, if_rvalid, d_rvalid);
        else n_pass++;
        rst = 1'b0;
        step();
        n_checks++;
        if (if_rvalid !== 1'b0) $display("FAIL rstmid_norvalid got %b want 0", if_rvalid);
        else n_pass++;
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        #1;
        n_checks++;
        if ({if_gnt, d_gnt} !== 2'b10) $display("FAIL rstmid_tie got %b want 10", {if_gnt, d_gnt});
        else n_pass++;
        step(); if_req = 1'b0; d_req = 1'b0;
        m_ack = 1'b1;
        step(); m_ack = 1'b0;
        step();
    endtask

    // Reference: a tie goes to whoever was not served last (fetch after reset);
    // a transaction completes with memory data if acked within TO cycles,
    // otherwise with err=1 and zero data; stores always return zero data.
    task automatic test_random(input int n);
        bit          last_was_d, fr, dr, own_d, we, exp_err;
        logic [31:0] addr, wd, rd, exp_rd;
        logic [2:0]  f3;
        logic [69:0] got, want;
        int          lat;
        rst = 1'b1; step(); rst = 1'b0;
        last_was_d = 1'b1;
        repeat (n) begin
            fr = 1'($urandom_range(0, 1)); dr = 1'($urandom_range(0, 1));
            if_req = fr; if_addr = $urandom;
            d_req = dr; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom;
            d_wdata = $urandom; d_funct3 = 3'($urandom_range(0, 7));
            #1;
            own_d = (fr && dr) ? !last_was_d : dr;
            n_checks++;
            if ({if_gnt, d_gnt} !== ((fr || dr) ? {!own_d, own_d} : 2'b00))
                $display("FAIL rand_gnt req=%b%b got %b want %b", fr, dr, {if_gnt, d_gnt},
                         (fr || dr) ? {!own_d, own_d} : 2'b00);
            else n_pass++;
            if (!(fr || dr)) begin
                step();
                if_req = 1'b0; d_req = 1'b0;
            end else begin
                last_was_d = own_d;
                we   = own_d ? d_we : 1'b0;
                addr = own_d ? d_addr : if_addr;
                wd   = own_d ? d_wdata : 32'h0;
                f3   = own_d ? d_funct3 : 3'b010;
                lat  = $urandom_range(1, TO + 2);
                rd   = $urandom;
                step(); if_req = 1'b0; d_req = 1'b0;
                for (int c = 1; c <= TO; c++) begin
                    n_checks++;
                    if ({m_req, m_we, m_addr, m_wdata, m_funct3} !== {1'b1, we, addr, wd, f3})
                        $display("FAIL rand_mfields_c%0d got %b/%b/%h/%h/%b want 1/%b/%h/%h/%b",
                                 c, m_req, m_we, m_addr, m_wdata, m_funct3, we, addr, wd, f3);
                    else n_pass++;
                    if (c == lat) begin m_ack = 1'b1; m_rdata = rd; end
                    step();
                    m_ack = 1'b0;
                    if (c == lat) break;
                end
                exp_err = (lat > TO);
                exp_rd  = (exp_err || we) ? 32'h0 : rd;
                #1;
                got  = {m_req, if_rvalid, if_err, if_rdata, d_rvalid, d_err, d_rdata[31:31]};
                want = own_d ? {1'b0, 1'b0, 1'b0, 32'h0, 1'b1, exp_err, exp_rd[31:31]}
                             : {1'b0, 1'b1, exp_err, exp_rd, 1'b0, 1'b0, 1'b0};
                n_checks++;
                if (got !== want || d_rdata !== (own_d ? exp_rd : 32'h0))
                    $display("FAIL rand_resp lat=%0d own_d=%b if=%b/%b/%h d=%b/%b/%h want err=%b rd=%h",
                             lat, own_d, if_rvalid, if_err, if_rdata, d_rvalid, d_err, d_rdata,
                             exp_err, exp_rd);
                else n_pass++;
                step();
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired after 200000 time units");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fetch_basic();
        test_alternation();
        test_store();
        test_timeout();
        test_ack_on_timeout();
        test_rst_mid();
        test_random(60);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
